// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the unified memory port arbiter.
// slave is the arbiter's view; master is the view of the core and memory around it.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              sel;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_done, if_rdata, d_done, d_rdata, sel, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_done, if_rdata, d_done, d_rdata, sel, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/NBitMUX2x1.sv
// N-bit two-input multiplexer: y = s ? b : a.
module NBitMUX2x1 #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         s,
    output logic [N-1:0] y
);
    assign y = s ? b : a;
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// DATA wins ties; a streak counter forces an IF grant after STARVE_LIMIT DATA grants.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned       StreakW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StBusyIf, StBusyD} state_e;

    state_e             state_q, state_d;
    logic               sel_q, sel_d;
    logic [StreakW-1:0] streak_q, streak_d;
    logic               busy;
    logic [ADDR_W-1:0]  addr_mux;
    logic               we_mux;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sel_q    <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        streak_d = streak_q;
        unique case (state_q)
            StIdle: begin
                if (bus.d_req && (!bus.if_req || streak_q < StreakMax)) begin
                    state_d = StBusyD;
                    sel_d   = 1'b1;
                    // Streak only counts DATA grants that made a waiting IF request lose.
                    if (!bus.if_req) begin
                        streak_d = '0;
                    end else if (streak_q != StreakMax) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (bus.if_req) begin
                    state_d  = StBusyIf;
                    sel_d    = 1'b0;
                    streak_d = '0;
                end
            end
            StBusyIf, StBusyD: begin
                if (bus.mem_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);

    NBitMUX2x1 #(.N(ADDR_W)) u_addr_mux (
        .a(bus.if_addr),
        .b(bus.d_addr),
        .s(sel_q),
        .y(addr_mux)
    );

    NBitMUX2x1 #(.N(1)) u_we_mux (
        .a(1'b0),
        .b(bus.d_we),
        .s(sel_q),
        .y(we_mux)
    );

    assign bus.sel       = sel_q;
    assign bus.mem_en    = busy;
    assign bus.mem_we    = busy & we_mux;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = bus.d_wdata;
    assign bus.if_done   = (state_q == StBusyIf) & bus.mem_ready;
    assign bus.d_done    = (state_q == StBusyD) & bus.mem_ready;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized requesters and memory,
// every cycle compared against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: who owns the port (0 none, 1 IF, 2 DATA), the last grant and the DATA-win streak.
    int owner       = 0;
    bit m_sel       = 1'b0;
    int m_streak    = 0;
    bit model_valid = 1'b0;
    int last_done   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        if (!model_valid) return;
        check_eq("mem_en", bus.mem_en, owner != 0);
        check_eq("mem_we", bus.mem_we, owner == 2 && bus.d_we);
        check_eq("sel", bus.sel, m_sel);
        check_eq("if_done", bus.if_done, owner == 1 && bus.mem_ready);
        check_eq("d_done", bus.d_done, owner == 2 && bus.mem_ready);
        if (owner != 0)
            check_eq("mem_addr", bus.mem_addr, (owner == 2) ? bus.d_addr : bus.if_addr);
        if (owner == 2 && bus.d_we) check_eq("mem_wdata", bus.mem_wdata, bus.d_wdata);
        if (owner == 1 && bus.mem_ready) check_eq("if_rdata", bus.if_rdata, bus.mem_rdata);
        if (owner == 2 && bus.mem_ready && !bus.d_we)
            check_eq("d_rdata", bus.d_rdata, bus.mem_rdata);
    endtask

    task automatic model_step();
        last_done = 0;
        if (rst) begin
            owner       = 0;
            m_sel       = 1'b0;
            m_streak    = 0;
            model_valid = 1'b1;
        end else if (owner != 0) begin
            if (bus.mem_ready) begin
                last_done = owner;
                owner     = 0;
            end
        end else if (bus.d_req && (!bus.if_req || m_streak < STARVE_LIMIT)) begin
            owner    = 2;
            m_sel    = 1'b1;
            m_streak = bus.if_req ? m_streak + 1 : 0;
        end else if (bus.if_req) begin
            owner    = 1;
            m_sel    = 1'b0;
            m_streak = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    logic [4:0] starve_seq;
    int         grant_idx;

    initial begin
        rst           = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_sel", bus.sel, 1'b0);
        check_eq("rst_mem_en", bus.mem_en, 1'b0);
        check_eq("rst_mem_we", bus.mem_we, 1'b0);
        check_eq("rst_if_done", bus.if_done, 1'b0);
        check_eq("rst_d_done", bus.d_done, 1'b0);

        // Single IF read, zero-wait memory
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h40;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0050_0093;
        tick();
        #1;
        check_eq("ifr_mem_en", bus.mem_en, 1'b1);
        check_eq("ifr_addr", bus.mem_addr, 32'h40);
        check_eq("ifr_we", bus.mem_we, 1'b0);
        check_eq("ifr_done", bus.if_done, 1'b1);
        check_eq("ifr_rdata", bus.if_rdata, 32'h0050_0093);
        tick();
        bus.if_req = 1'b0;
        #1;
        check_eq("ifr_idle", bus.mem_en, 1'b0);

        // DATA store with three wait states
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b1;
        bus.d_addr    = 32'h100;
        bus.d_wdata   = 32'hDEAD_BEEF;
        bus.mem_ready = 1'b0;
        tick();
        for (int k = 1; k <= 4; k++) begin
            bus.mem_ready = (k == 4);
            #1;
            check_eq("st_en", bus.mem_en, 1'b1);
            check_eq("st_we", bus.mem_we, 1'b1);
            check_eq("st_sel", bus.sel, 1'b1);
            check_eq("st_d_done", bus.d_done, k == 4);
            check_eq("st_if_done", bus.if_done, 1'b0);
            tick();
        end
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;

        // Priority: simultaneous requests, DATA first, then IF
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h200;
        bus.d_req     = 1'b1;
        bus.d_addr    = 32'h300;
        bus.mem_ready = 1'b1;
        tick();
        #1;
        check_eq("pri_sel_d", bus.sel, 1'b1);
        check_eq("pri_d_done", bus.d_done, 1'b1);
        tick();
        bus.d_req = 1'b0;
        tick();
        #1;
        check_eq("pri_sel_if", bus.sel, 1'b0);
        check_eq("pri_if_done", bus.if_done, 1'b1);
        check_eq("pri_if_addr", bus.mem_addr, 32'h200);
        tick();

        // Build up a streak, abort a DATA access with reset, then check the starvation pattern
        bus.d_req = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        bus.mem_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check_eq("abort_no_done", bus.d_done, 1'b0);
        check_eq("abort_en_before", bus.mem_en, 1'b1);
        tick();
        rst           = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        check_eq("abort_mem_en", bus.mem_en, 1'b0);
        check_eq("abort_sel", bus.sel, 1'b0);
        check_eq("abort_d_done", bus.d_done, 1'b0);

        // Expected grant pattern per 5 grants: D,D,D,D,I (1 = DATA)
        starve_seq = 5'b01111;
        grant_idx  = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.mem_en) begin
                check_eq("starve_grant", bus.sel, starve_seq[grant_idx%5]);
                grant_idx++;
            end
            tick();
        end
        check_eq("starve_grants", grant_idx, 10);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        tick();

        // Back-to-back DATA loads
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0;
        for (int c = 0; c < 6; c++) begin
            bus.mem_rdata = 32'h1000 + c;
            #1;
            check_eq("b2b_done", bus.d_done, c % 2 == 1);
            if (c % 2 == 1) begin
                check_eq("b2b_addr", bus.mem_addr, 32'((c / 2) * 4));
                check_eq("b2b_rdata", bus.d_rdata, 32'h1000 + c);
            end
            tick();
            if (c % 2 == 1) bus.d_addr = bus.d_addr + 32'h4;
        end
        bus.d_req = 1'b0;
        tick();

        // Randomized requesters and memory
        for (int c = 0; c < 3000; c++) begin
            if (!bus.if_req && $urandom_range(0, 3) == 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = $urandom();
            end
            if (!bus.d_req && $urandom_range(0, 2) == 0) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = $urandom();
                bus.d_wdata = $urandom();
            end
            bus.mem_ready = ($urandom_range(0, 2) != 0);
            bus.mem_rdata = $urandom();
            rst = !bus.mem_ready && ($urandom_range(0, 99) == 0);
            tick();
            rst = 1'b0;
            if (last_done == 1) begin
                bus.if_req  = 1'($urandom_range(0, 1));
                bus.if_addr = $urandom();
            end
            if (last_done == 2) begin
                bus.d_req   = 1'($urandom_range(0, 1));
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = $urandom();
                bus.d_wdata = $urandom();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported unified memory between the instruction-fetch requester (IF) and the data-access requester (DATA) of the pipelined RISC-V core. A registered select drives NBitMUX2x1 instances that steer address, write data and write-enable onto the memory port. DATA has priority, and a starvation guard bounds IF wait time. The arbiter returns per-requester completion strobes that the hazard unit uses to stall the pipeline.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, max consecutive DATA grants while IF waits (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  IF access request (read only)
- if_addr  in  ADDR_W  IF address
- if_done  out  1  IF access completes this cycle
- if_rdata  out  DATA_W  IF read data, valid when if_done
- d_req  in  1  DATA access request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  DATA address
- d_wdata  in  DATA_W  store data
- d_done  out  1  DATA access completes this cycle
- d_rdata  out  DATA_W  load data, valid when d_done and !d_we
- sel  out  1  registered grant, 0 = IF, 1 = DATA
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completes the access this cycle

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_D.
- IDLE: no grant is made if neither request is high. Otherwise the next state is chosen as follows:
  - Only if_req high: go to BUSY_IF, sel←0.
  - Only d_req high: go to BUSY_D, sel←1.
  - Both high and streak < STARVE_LIMIT: go to BUSY_D, sel←1.
  - Both high and streak == STARVE_LIMIT: go to BUSY_IF, sel←0.
- streak counter (width clog2(STARVE_LIMIT+1)), updated only on IDLE grant decisions:
  - Increments (saturating) on a DATA grant while if_req is high.
  - Clears on an IF grant or when a DATA grant occurs with if_req low.
- BUSY_x:
  - mem_en=1.
  - mem_addr = sel ? d_addr : if_addr. mem_wdata = d_wdata. mem_we = sel & d_we. These are steered through NBitMUX2x1 on sel.
  - When mem_ready=1: x_done=1 combinationally in that cycle, x_rdata = mem_rdata, and the next state is IDLE.
  - When mem_ready=0: remain in BUSY_x.
- Outside BUSY, mem_en=0 and mem_we=0. if_done/d_done are never high outside the matching BUSY state. Both are never high together.
- Requester rules:
  - Hold req, addr, we and wdata stable from assertion until done.
  - A req still high in the cycle after done is a new request.
- mem_ready sampled outside BUSY is ignored.
- if_rdata/d_rdata are don't-care when the matching done is low. Drive mem_rdata through unconditionally.

## Timing
- Reset values: state IDLE, sel=0, streak=0, mem_en=0, mem_we=0, if_done=0, d_done=0.
- Reset mid-access: the access is aborted, no done is issued, and mem_en is 0 from the cycle after rst is sampled.
- Latency: req seen in IDLE at cycle n → mem_en at n+1 → done in the first cycle ≥ n+1 with mem_ready=1. Minimum is 2 cycles per access.
- Throughput: back-to-back requests cost one IDLE cycle each. A continuously held d_req gets 1 access per 2 cycles with a zero-wait memory.
- Bound: with both requests continuously high, IF is granted at least once every STARVE_LIMIT+1 grants.
- A request arriving mid-BUSY is only evaluated in the next IDLE. A request dropped before its grant is never granted.

## Test plan
- Reset mid-access: rst asserted while in BUSY_D with mem_ready=0 → next cycle mem_en=0, sel=0, no d_done, streak=0.
- Single IF read: if_req=1, if_addr=0x40, mem_ready tied 1, mem_rdata=0x00500093 → mem_en at cycle 1 with mem_addr=0x40 and mem_we=0, if_done=1 with if_rdata=0x00500093 at cycle 1, IDLE at cycle 2.
- DATA store with wait states: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, mem_ready low 3 cycles then high → mem_en/mem_we/sel held at 1 for 4 cycles, d_done only in cycle 4, no if_done.
- Priority: if_req and d_req rise together, STARVE_LIMIT=4 → first grant is DATA (sel=1); IF is served after DATA completes if d_req then drops.
- Starvation guard: both requests held high continuously, STARVE_LIMIT=4, zero-wait memory → grant sequence D,D,D,D,I,D,D,D,D,I; streak returns to 0 after each IF grant.
- Back-to-back: d_req held high for 3 accesses with changing addresses 0x0,0x4,0x8 → d_done in cycles 1,3,5 and mem_addr matches each address in its BUSY cycle.
